// File: rtl/fifo_pkg.sv
// Shared constants for the sync_fifo read-side adapter: default widths and skid-buffer occupancy codes.
package fifo_pkg;

    localparam int DEF_FIFO_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry head/tail skid buffer; a captured word is visible on head one cycle later.
// Never refuses a capture: the caller only issues reads when a slot is guaranteed.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  cap_vld,
    input  logic [FIFO_WIDTH-1:0] cap_dat,
    input  logic                  pop,
    output occ_t                  occ,
    output logic [FIFO_WIDTH-1:0] head
);

    occ_t                  occ_q, occ_d;
    logic [FIFO_WIDTH-1:0] head_q, head_d;
    logic [FIFO_WIDTH-1:0] tail_q, tail_d;
    logic                  cap;

    // The word landing during a flush is dropped along with everything buffered.
    assign cap = cap_vld & ~flush;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q + {1'b0, cap} - {1'b0, pop};

        if (pop && occ_q == OCC_FULL) begin
            head_d = tail_q;
        end

        if (cap) begin
            if (occ_q == OCC_EMPTY || (occ_q == OCC_ONE && pop)) begin
                head_d = cap_dat;
            end else begin
                tail_d = cap_dat;
            end
        end

        if (flush) begin
            occ_d = OCC_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign occ  = occ_q;
    assign head = head_q;

endmodule

// File: rtl/sync_fifo_rd_adapter.sv
// Pops a sync_fifo into a valid/ready stream; first word valid two cycles after rd_en, then 1 word/cycle.
// Stalls on !m_ready after at most one more pop; rd_en only issues when a buffer slot is guaranteed.
module sync_fifo_rd_adapter
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);

    logic                  inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    occ_t                  occ;
    logic [FIFO_WIDTH-1:0] head;
    logic                  pop;
    logic [2:0]            level;

    assign m_valid = (occ != OCC_EMPTY);
    assign m_data  = head;
    assign pop     = m_valid & m_ready;

    // Slots committed after this edge; counting the same-cycle pop keeps streaming at full rate.
    assign level      = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = ~rst & ~flush & ~fifo_empty & (level < 3'd2);

    assign inflight_d = fifo_rd_en;
    assign beat_cnt_d = beat_cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;

    fifo_skid_buf #(
        .FIFO_WIDTH (FIFO_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .cap_vld (inflight_q),
        .cap_dat (fifo_rd_data),
        .pop     (pop),
        .occ     (occ),
        .head    (head)
    );

endmodule

// File: doc/sync_fifo_rd_adapter.md
# sync_fifo_rd_adapter

Read-side adapter between a `sync_fifo` read port and a downstream valid/ready stream consumer. It pops words with `rd_en` only when the FIFO is non-empty and buffer space is guaranteed, absorbs the FIFO's one-cycle read latency in a two-entry skid buffer, and presents words in order on `m_valid/m_ready/m_data`. It sits at the consumer end of every `sync_fifo` instance whose downstream logic can stall. By construction it never provokes `rd_err`.

## Interface
- `FIFO_WIDTH`, 32, data word width; must match the attached `sync_fifo`.
- `CNT_WIDTH`, 16, width of the transferred-beat counter.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard all buffered and in-flight words.
- `fifo_empty` in 1: `empty` from `sync_fifo`.
- `fifo_rd_data` in FIFO_WIDTH: `rd_data` from `sync_fifo`, valid the cycle after an accepted `rd_en`.
- `fifo_rd_en` out 1: `rd_en` to `sync_fifo`.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: consumer accepts `m_data` when it is high together with `m_valid`.
- `m_data` out FIFO_WIDTH: output word (head of buffer).
- `beat_cnt` out CNT_WIDTH: number of accepted output beats, wraps modulo 2^CNT_WIDTH.

## Operation
- State: `occ` (0/1/2 buffered words), `inflight` (1 when `fifo_rd_en` was high last cycle), two data registers `head`/`tail`.
- `pop = m_valid & m_ready`.
- `fifo_rd_en = !rst & !flush & !fifo_empty & (occ + inflight - pop < 2)`. This is combinational and includes the same-cycle `m_ready`.
- Capture: when `inflight` is set, `fifo_rd_data` is written into the buffer:
  - to `head` if `occ` is 0, or if `occ` is 1 and `pop` is high;
  - otherwise to `tail`.
- On `pop` with `occ` = 2, `tail` moves to `head`.
- Occupancy update: `occ_next = occ + inflight - pop`. It never exceeds 2; an overflow is a design error, covered by a bench assertion.
- `m_valid = (occ != 0)`, `m_data = head`. Both are registered; there is no combinational path from `fifo_rd_data` to `m_data`.
- `m_data` holds its value while `m_valid & !m_ready`. A word, once valid, never changes until accepted.
- `beat_cnt` increments on every `pop`.
- `flush`:
  - next `occ` is 0 and next `inflight` is 0;
  - the word arriving in the flush cycle is discarded;
  - `fifo_rd_en` is 0 during the flush cycle;
  - a `pop` coinciding with `flush` still counts in `beat_cnt`.
- `rst` has the same effect as `flush`. In addition:
  - `beat_cnt` is 0, `m_data` is 0, `m_valid` is 0;
  - `fifo_rd_en` is 0 throughout reset.

## Timing
- Latency: FIFO non-empty with the buffer empty in cycle N gives `fifo_rd_en` in N, data on `fifo_rd_data` in N+1, and `m_valid` = 1 in N+2.
- Throughput: 1 word/cycle sustained while `m_ready` is high and the FIFO is non-empty.
- Stall: once `m_ready` drops, at most one further word is popped (the in-flight one plus one buffered). After that, `fifo_rd_en` stays 0 until `pop`.
- Restart from full (`occ` 2): `pop` in cycle K re-enables `fifo_rd_en` in the same cycle K.
- `fifo_empty` goes high mid-stream: `fifo_rd_en` drops the same cycle. Buffered words still drain.
- Reset release: the first `fifo_rd_en` can occur in the first cycle with `rst` low.

## Structure
- Package `fifo_pkg`: `FIFO_WIDTH` default, `CNT_WIDTH` default, and the occupancy constants `OCC_EMPTY`/`OCC_ONE`/`OCC_FULL` (2-bit).
- Sub-module `fifo_skid_buf`: the 2-entry head/tail buffer with `occ`.
  - Inputs: capture strobe, capture data, `pop`, `flush`.
  - Outputs: `occ`, `head`.
- The top level holds `inflight`, the `fifo_rd_en` logic and `beat_cnt`.

## Test plan
- **Burst drain, consumer always ready.** Write 1..8 into a depth-8 `sync_fifo` (2 of 10 writes rejected with `wr_err`), then hold `m_ready`=1. Required: `m_data` = 1..8 on consecutive cycles, first `m_valid` 2 cycles after the first `fifo_rd_en`, `rd_err` never set, `beat_cnt`=8, final `empty`=1.
- **Consumer stall.** 8 words queued; toggle `m_ready` 1-0-0-1-0-1… Required: no word lost or duplicated (sequence 1..8), `occ` ≤ 2, at most 2 pops during any stall, `m_data` stable while stalled.
- **Trickle.** One write every 10 cycles with `m_ready`=1. Required: each word appears on `m_valid` exactly 3 cycles after its write, with `m_valid` low between words.
- **Flush with in-flight.** With `occ`=2 and `inflight`=1 (words 3, 4 buffered, 5 in flight), pulse `flush`. Required: `m_valid`=0 next cycle, word 5 discarded, next output is 6.
- **Reset mid-stream.** Assert `rst` during a stalled transfer. Required: `m_valid`=0, `m_data`=0, `beat_cnt`=0, `fifo_rd_en`=0 through reset; normal draining resumes after release.
- **Counter wrap.** With `CNT_WIDTH`=4, transfer 17 beats. Required: `beat_cnt`=1.
